// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with a valid/ready
// handshake, a synchronous flush that loads a configurable bubble, and an
// optional two-entry skid buffer.
//
// Build option:
//   PIPE_STAGE_REG_SKID_EN defined   -> main + skid entries; in_ready is a
//                                       flop, so there is no combinational
//                                       path from out_ready to in_ready.
//   PIPE_STAGE_REG_SKID_EN undefined -> single main entry; in_ready is
//                                       combinational (!out_valid || out_ready).
//
// Edge priority is reset > flush > handshake. Whenever the stage holds no
// valid entry the data registers hold BUBBLE, so out_data reads BUBBLE
// while out_valid is low without any output mux.

module pipe_stage_reg #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    // Bit 0 of the encoding is "main entry valid", so out_valid comes
    // straight from a flop. FULL is only reachable in the skid build.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic              accept;
    logic              consume;

    assign out_valid = state_q[0];
    assign out_data  = main_q;
    assign consume   = state_q[0] && out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN

    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_ready_q;

    assign in_ready = in_ready_q;
    assign accept   = in_valid && in_ready_q;

    // Next-state and next-data for the EMPTY/ONE/FULL skid machine; flush overrides the handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = ST_FULL;
                    skid_d  = in_data;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d = ST_ONE;
                    main_d  = skid_q;
                    skid_d  = BUBBLE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = BUBBLE;
                skid_d  = BUBBLE;
            end
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end
    end

    // State, data and the registered in_ready, all with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

`else

    assign in_ready = !state_q[0] || out_ready;
    assign accept   = in_valid && in_ready;

    // Next-state and next-data for the single-entry register; flush overrides the handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (accept) begin
                    main_d = in_data;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = BUBBLE;
            end
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg. A queue-based
// reference of the stage contents acts as scoreboard (push on accept, pop
// on consume, cleared on flush/reset); a vector table covers streaming and
// hand-written sequences cover backpressure, flush and reset corner cases.
// Works for both builds (PIPE_STAGE_REG_SKID_EN defined or not).

module tb_pipe_stage_reg;

    localparam int           DW     = 16;
    localparam logic [DW-1:0] BUB   = 16'h0013;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];
    bit            model_known = 0;

    logic          smp_valid;
    logic          smp_ready;
    logic [DW-1:0] smp_data;

    typedef struct {
        bit            iv;
        logic [DW-1:0] data;
        bit            ordy;
        bit            exp_valid;
        logic [DW-1:0] exp_data;
        bit            exp_ready;
    } vec_t;

    vec_t vecs[10];

    pipe_stage_reg #(
        .DATA_W (DW),
        .BUBBLE (BUB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit modelReady(input bit ordy);
`ifdef PIPE_STAGE_REG_SKID_EN
        return model_q.size() < 2;
`else
        return (model_q.size() == 0) || ordy;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, sample and check against the model, then
    // update the model at the rising edge. acc reports a handshake.
    task automatic applyStimulus(input bit rst, input bit fl, input bit iv,
                                 input logic [DW-1:0] d, input bit ordy,
                                 output bit acc);
        bit exp_rdy;
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        smp_valid = out_valid;
        smp_ready = in_ready;
        smp_data  = out_data;
        exp_rdy   = modelReady(ordy);
        if (model_known) begin
            checkOutput("sb_in_ready", 64'(smp_ready), 64'(exp_rdy));
            checkOutput("sb_out_valid", 64'(smp_valid), 64'(model_q.size() > 0));
            checkOutput("sb_out_data", 64'(smp_data),
                        (model_q.size() > 0) ? 64'(model_q[0]) : 64'(BUB));
        end
        acc = iv && exp_rdy;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_known = 1;
        end else if (fl) begin
            model_q.delete();
        end else if (model_known) begin
            if (model_q.size() > 0 && ordy) void'(model_q.pop_front());
            if (acc) model_q.push_back(d);
        end
    endtask

    initial begin
        bit            acc;
        logic [DW-1:0] pending[$];
        bit            have_pend;
        logic [DW-1:0] pend_data;

        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Streaming table: 1..8 back-to-back, one-cycle latency, then drain.
        for (int i = 0; i < 10; i++) begin
            vecs[i].iv        = (i < 8);
            vecs[i].data      = (i < 8) ? DW'(i + 1) : '0;
            vecs[i].ordy      = 1'b1;
            vecs[i].exp_valid = (i >= 1) && (i <= 8);
            vecs[i].exp_data  = vecs[i].exp_valid ? DW'(i) : BUB;
            vecs[i].exp_ready = 1'b1;
        end

        // Reset held two cycles, then idle.
        applyStimulus(1, 0, 0, '0, 0, acc);
        applyStimulus(1, 0, 0, '0, 0, acc);
        applyStimulus(0, 0, 0, '0, 0, acc);
        checkOutput("rst_in_ready", 64'(smp_ready), 64'(1));
        checkOutput("rst_out_valid", 64'(smp_valid), 64'(0));
        checkOutput("rst_out_data", 64'(smp_data), 64'(BUB));

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, vecs[i].iv, vecs[i].data, vecs[i].ordy, acc);
            checkOutput("tbl_out_valid", 64'(smp_valid), 64'(vecs[i].exp_valid));
            checkOutput("tbl_out_data", 64'(smp_data), 64'(vecs[i].exp_data));
            checkOutput("tbl_in_ready", 64'(smp_ready), 64'(vecs[i].exp_ready));
        end

        // Backpressure: A, B, C offered with out_ready low for 4 cycles.
        pending = '{16'h000A, 16'h000B, 16'h000C};
        for (int c = 0; c < 12; c++) begin
            applyStimulus(0, 0, pending.size() > 0,
                          (pending.size() > 0) ? pending[0] : '0, c >= 4, acc);
            if (c == 1) checkOutput("bp_hold_a", 64'(smp_data), 64'(16'h000A));
            if (c == 3) checkOutput("bp_stall_a", 64'(smp_data), 64'(16'h000A));
            if (acc) void'(pending.pop_front());
        end
        checkOutput("bp_all_accepted", 64'(pending.size()), 64'(0));
        checkOutput("bp_drained", 64'(smp_valid), 64'(0));

        // Flush with concurrent offer of 0xD.
        applyStimulus(0, 0, 1, 16'h0001, 0, acc);
        applyStimulus(0, 0, 1, 16'h0002, 0, acc);
        applyStimulus(0, 1, 1, 16'h000D, 1, acc);
        applyStimulus(0, 0, 0, '0, 1, acc);
        checkOutput("fl_out_valid", 64'(smp_valid), 64'(0));
        checkOutput("fl_out_data", 64'(smp_data), 64'(BUB));
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0, '0, 1, acc);
            checkOutput("fl_no_0xd", 64'(smp_data == 16'h000D), 64'(0));
        end

        // Reset beats flush while an entry is held; 0xE passes afterwards.
        applyStimulus(0, 0, 1, 16'h0003, 0, acc);
        applyStimulus(1, 1, 1, 16'h0007, 0, acc);
        applyStimulus(0, 0, 1, 16'h000E, 1, acc);
        checkOutput("rf_empty", 64'(smp_valid), 64'(0));
        checkOutput("rf_ready", 64'(smp_ready), 64'(1));
        applyStimulus(0, 0, 0, '0, 1, acc);
        checkOutput("rf_latency_valid", 64'(smp_valid), 64'(1));
        checkOutput("rf_latency_data", 64'(smp_data), 64'(16'h000E));
        applyStimulus(0, 0, 0, '0, 1, acc);

        // Random traffic with upstream holding data until accepted.
        have_pend = 0;
        pend_data = '0;
        for (int c = 0; c < 400; c++) begin
            if (!have_pend && $urandom_range(0, 3) != 0) begin
                have_pend = 1;
                pend_data = DW'($urandom);
            end
            applyStimulus(0, $urandom_range(0, 29) == 0, have_pend, pend_data,
                          $urandom_range(0, 2) != 0, acc);
            if (acc) have_pend = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
